// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall control block.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hz_state_t;

    localparam logic [4:0]  REG_ZERO       = 5'd0;
    localparam int unsigned MULT_CYCLES_DEF = 4;
    localparam int unsigned DIV_CYCLES_DEF  = 32;

endpackage

// File: rtl/md_wait_timer.sv
// Down-counter timing the remaining mult/div stall cycles; zero flags the last one.
module md_wait_timer #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use stall, taken-branch flush and mult/div freeze control for the 5-stage pipeline.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush event counters.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ID_EX_MemRead,
    input  logic [4:0] ID_EX_RT,
    input  logic [4:0] RS_ADDR,
    input  logic [4:0] RT_ADDR,
    input  logic       ID_UsesRT,
    input  logic       EX_BranchTaken,
    input  logic       EX_MdStart,
    input  logic       EX_MdIsDiv,
    output logic       PC_Write,
    output logic       IF_ID_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       EX_Hold,
    output logic       EX_MEM_Bubble,
    output logic       Md_Busy,
    output logic       Md_Done
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] Stall_Count,
    output logic [31:0] Flush_Count
`endif
);

    // The start cycle and the zero-count cycle both stall, hence the -2.
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);

    hz_state_t        state;
    logic             load_use;
    logic             md_start;
    logic             md_dec;
    logic             md_zero;
    logic [CNT_W-1:0] md_load_val;

    assign load_use = ID_EX_MemRead && (ID_EX_RT != REG_ZERO) &&
                      ((ID_EX_RT == RS_ADDR) || (ID_UsesRT && (ID_EX_RT == RT_ADDR)));
    assign md_start    = (state == RUN) && !EX_BranchTaken && EX_MdStart;
    assign md_dec      = (state == MD_WAIT) && !md_zero;
    assign md_load_val = EX_MdIsDiv ? DIV_LOAD : MULT_LOAD;

    md_wait_timer #(.CNT_W(CNT_W)) u_md_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (md_start),
        .load_val (md_load_val),
        .dec      (md_dec),
        .zero     (md_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (md_start) state <= MD_WAIT;
                MD_WAIT: if (md_zero)  state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        EX_Hold       = 1'b0;
        EX_MEM_Bubble = 1'b0;
        Md_Busy       = 1'b0;
        Md_Done       = 1'b0;
        if (state == MD_WAIT) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            EX_Hold       = 1'b1;
            EX_MEM_Bubble = 1'b1;
            Md_Busy       = 1'b1;
            Md_Done       = md_zero;
        end else if (EX_BranchTaken) begin
            IF_ID_Flush   = 1'b1;
            ID_EX_Flush   = 1'b1;
        end else if (EX_MdStart) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            EX_Hold       = 1'b1;
            EX_MEM_Bubble = 1'b1;
            Md_Busy       = 1'b1;
        end else if (load_use) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Flush   = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Stall_Count <= '0;
            Flush_Count <= '0;
        end else begin
            if (!PC_Write && (Stall_Count != '1)) Stall_Count <= Stall_Count + 32'd1;
            if (IF_ID_Flush && (Flush_Count != '1)) Flush_Count <= Flush_Count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: behavioural model pushes expected outputs, negedge sampling pops them.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       ID_EX_MemRead;
    logic [4:0] ID_EX_RT;
    logic [4:0] RS_ADDR;
    logic [4:0] RT_ADDR;
    logic       ID_UsesRT;
    logic       EX_BranchTaken;
    logic       EX_MdStart;
    logic       EX_MdIsDiv;
    logic       PC_Write;
    logic       IF_ID_Write;
    logic       IF_ID_Flush;
    logic       ID_EX_Flush;
    logic       EX_Hold;
    logic       EX_MEM_Bubble;
    logic       Md_Busy;
    logic       Md_Done;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] Stall_Count;
    logic [31:0] Flush_Count;
`endif

    hazard_stall_unit #(
        .MULT_CYCLES (4),
        .DIV_CYCLES  (32),
        .CNT_W       (6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ID_EX_MemRead  (ID_EX_MemRead),
        .ID_EX_RT       (ID_EX_RT),
        .RS_ADDR        (RS_ADDR),
        .RT_ADDR        (RT_ADDR),
        .ID_UsesRT      (ID_UsesRT),
        .EX_BranchTaken (EX_BranchTaken),
        .EX_MdStart     (EX_MdStart),
        .EX_MdIsDiv     (EX_MdIsDiv),
        .PC_Write       (PC_Write),
        .IF_ID_Write    (IF_ID_Write),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Flush    (ID_EX_Flush),
        .EX_Hold        (EX_Hold),
        .EX_MEM_Bubble  (EX_MEM_Bubble),
        .Md_Busy        (Md_Busy),
        .Md_Done        (Md_Done)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .Stall_Count    (Stall_Count),
        .Flush_Count    (Flush_Count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] ctl;
        int         stalls;
        int         flushes;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   md_left  = 0;
    int   m_stalls = 0;
    int   m_flushes = 0;

    localparam logic [7:0] CTL_IDLE   = 8'b1100_0000;
    localparam logic [7:0] CTL_BRANCH = 8'b1111_0000;
    localparam logic [7:0] CTL_MD     = 8'b0000_1110;
    localparam logic [7:0] CTL_LU     = 8'b0001_0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dut_ctl();
        return {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
                EX_Hold, EX_MEM_Bubble, Md_Busy, Md_Done};
    endfunction

    // Bit order {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_Hold, EX_MEM_Bubble, Md_Busy, Md_Done}
    function automatic logic [7:0] model_ctl();
        logic hit;
        hit = ID_EX_MemRead && (ID_EX_RT != 5'd0) &&
              ((ID_EX_RT == RS_ADDR) || (ID_UsesRT && (ID_EX_RT == RT_ADDR)));
        if (md_left > 0)     return {7'b0000_111, md_left == 1};
        if (EX_BranchTaken)  return CTL_BRANCH;
        if (EX_MdStart)      return CTL_MD;
        if (hit)             return CTL_LU;
        return CTL_IDLE;
    endfunction

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        check(e.tag, {24'd0, dut_ctl()}, {24'd0, e.ctl});
`ifdef HAZARD_PERF_CNT_EN
        check({e.tag, "_stall_cnt"}, Stall_Count, e.stalls);
        check({e.tag, "_flush_cnt"}, Flush_Count, e.flushes);
`endif
    endtask

    task automatic step(input string tag, input logic br, input logic mr,
                        input logic [4:0] ex_rt, input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses, input logic mds, input logic div);
        exp_t e;
        @(posedge clk);
        #1;
        EX_BranchTaken = br;
        ID_EX_MemRead  = mr;
        ID_EX_RT       = ex_rt;
        RS_ADDR        = rs;
        RT_ADDR        = rt;
        ID_UsesRT      = uses;
        EX_MdStart     = mds;
        EX_MdIsDiv     = div;
        e.tag     = tag;
        e.ctl     = model_ctl();
        e.stalls  = m_stalls;
        e.flushes = m_flushes;
        sb.push_back(e);
        @(negedge clk);
        compare_front();
        if (!e.ctl[7]) m_stalls++;
        if (e.ctl[5])  m_flushes++;
        if (md_left > 0)
            md_left--;
        else if (!br && mds)
            md_left = div ? 31 : 3;
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        EX_BranchTaken = 0; ID_EX_MemRead = 0; ID_EX_RT = '0; RS_ADDR = '0;
        RT_ADDR = '0; ID_UsesRT = 0; EX_MdStart = 0; EX_MdIsDiv = 0;
        #3;
        e.tag = "reset"; e.ctl = CTL_IDLE; e.stalls = 0; e.flushes = 0;
        sb.push_back(e);
        compare_front();
        @(posedge clk);
        #1 rst = 1'b0;

        // load-use detection and register-0 / unused-rt exclusions
        step("lu_rs",        0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0);
        step("lu_release",   0, 0, 5'd8, 5'd8, 5'd0, 0, 0, 0);
        step("lu_r0",        0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
        step("lu_rt_unused", 0, 1, 5'd9, 5'd1, 5'd9, 0, 0, 0);
        step("lu_rt_used",   0, 1, 5'd9, 5'd1, 5'd9, 1, 0, 0);
        step("lu_no_load",   0, 0, 5'd9, 5'd9, 5'd9, 1, 0, 0);

        // multiply: 4-cycle stall, inputs ignored while waiting
        step("mul_start",    0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            step("mul_wait",   1, 1, 5'd8, 5'd8, 5'd8, 1, 0, 1);
        idle("mul_after");

        // branch priority
        step("br_over_lu",   1, 1, 5'd8, 5'd8, 5'd0, 0, 0, 0);
        step("br_over_md",   1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
        idle("br_after");

        // back-to-back multiplies with EX_MdStart held
        for (int i = 0; i < 5; i++)
            step("mul_b2b",    0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            idle("mul_b2b_drain");

        // full divide
        step("div_start",    0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
        for (int i = 0; i < 31; i++)
            step("div_wait",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        idle("div_after");

        // divide interrupted by asynchronous reset mid-stall
        step("div2_start",   0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
        for (int i = 0; i < 9; i++)
            step("div2_wait",  0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        md_left = 0; m_stalls = 0; m_flushes = 0;
        e.tag = "rst_mid_div"; e.ctl = CTL_IDLE; e.stalls = 0; e.flushes = 0;
        sb.push_back(e);
        compare_front();
        @(posedge clk);
        #1 rst = 1'b0;
        idle("post_rst_0");
        idle("post_rst_1");
        step("post_rst_lu",  0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0);
        idle("post_rst_2");

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Hazard control for the 5-stage MIPS pipeline. It sits beside the forwarding unit, one step upstream in control priority: the forwarding unit resolves hazards by bypass, and this block handles the cases bypass cannot cover.
- Load-use stall.
- Taken-branch flush.
- Multi-cycle multiply/divide freeze of the front end and EX.
Drives PC, IF/ID, ID/EX and EX/MEM write-enable and flush controls.

Parameters:
MULT_CYCLES, 4, total stall cycles for a multiply (legal range 2..63).
DIV_CYCLES, 32, total stall cycles for a divide (legal range 2..63).
CNT_W, 6, width of the internal mult/div wait counter.

Ports:
clk  in  1  pipeline clock; all state on rising edge.
rst  in  1  asynchronous, active-high reset.
ID_EX_MemRead  in  1  instruction in EX is a load.
ID_EX_RT  in  5  destination register of the load in EX.
RS_ADDR  in  5  rs field of the instruction in ID.
RT_ADDR  in  5  rt field of the instruction in ID.
ID_UsesRT  in  1  ID instruction reads rt as a source.
EX_BranchTaken  in  1  branch/jump in EX resolved taken.
EX_MdStart  in  1  mult/div instruction is in EX this cycle.
EX_MdIsDiv  in  1  1 = divide, 0 = multiply; valid with EX_MdStart.
PC_Write  out  1  PC load enable.
IF_ID_Write  out  1  IF/ID register load enable.
IF_ID_Flush  out  1  clear IF/ID to NOP.
ID_EX_Flush  out  1  load bubble into ID/EX.
EX_Hold  out  1  freeze ID/EX contents.
EX_MEM_Bubble  out  1  load bubble into EX/MEM.
Md_Busy  out  1  mult/div stall in progress.
Md_Done  out  1  one-cycle pulse in the last stall cycle.

Behaviour:
- FSM states are RUN and MD_WAIT. Reset puts the FSM in RUN with counter = 0.
- Reset output values: PC_Write=1, IF_ID_Write=1, all other outputs 0.
- Outputs are combinational from the state, the counter and the current inputs.

RUN state, priority high to low:
1. EX_BranchTaken=1: IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, IF_ID_Write=1. Any concurrent EX_MdStart is ignored and there is no state change.
2. EX_MdStart=1:
   - Asserts PC_Write=0, IF_ID_Write=0, EX_Hold=1, EX_MEM_Bubble=1, Md_Busy=1.
   - Next state is MD_WAIT, with the counter loaded to (EX_MdIsDiv ? DIV_CYCLES : MULT_CYCLES) - 2.
3. Load-use: ID_EX_MemRead=1 and ID_EX_RT != 0, and either ID_EX_RT == RS_ADDR or (ID_UsesRT and ID_EX_RT == RT_ADDR).
   - Asserts PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 for exactly one cycle.
   - No state change; the load advances to MEM and the forwarding unit supplies the operand.
4. Otherwise all outputs stay at their reset values.

Register $0 never creates a load-use hazard.

MD_WAIT state:
- Outputs held: PC_Write=0, IF_ID_Write=0, EX_Hold=1, EX_MEM_Bubble=1, Md_Busy=1.
- Counter decrements each cycle.
- When counter == 0: Md_Done=1 and next state is RUN.
- Total stall is exactly N cycles (start cycle plus N-1 MD_WAIT cycles).
- EX_BranchTaken, EX_MdStart and load-use inputs are ignored while in MD_WAIT.
- Back-to-back mult/div: a new EX_MdStart is honoured in the RUN cycle after Md_Done.

Reset during MD_WAIT: immediate return to RUN; the stall releases asynchronously.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs Stall_Count[31:0] and Flush_Count[31:0].
  - Stall_Count increments on each clock where PC_Write=0.
  - Flush_Count increments on each clock where IF_ID_Flush=1.
  - Both saturate at 32'hFFFFFFFF and are cleared by rst.
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

Decomposition:
Package hazard_pkg holds:
- The FSM state encoding (RUN=1'b0, MD_WAIT=1'b1).
- REG_ZERO = 5'd0.
- Default cycle constants MULT_CYCLES_DEF = 4 and DIV_CYCLES_DEF = 32.

One sub-module, md_wait_timer, is natural:
- Inputs: load, load value, decrement.
- Output: zero flag.
- Holds the CNT_W counter with async reset.

Test Plan:
1. Load-use on rs: ID_EX_MemRead=1, ID_EX_RT=8, RS_ADDR=8 -> one cycle with PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle (MemRead=0) all outputs return to reset values.
2. Load-use on $0 and on unused rt: ID_EX_RT=0, RS_ADDR=0 -> no stall; ID_EX_RT=9, RT_ADDR=9, ID_UsesRT=0 -> no stall.
3. Branch beats load-use: EX_BranchTaken=1 with a load-use match -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, IF_ID_Write=1.
4. Multiply, MULT_CYCLES=4: EX_MdStart=1, EX_MdIsDiv=0 at cycle T -> PC_Write=0 and Md_Busy=1 for cycles T..T+3; Md_Done=1 only at T+3; PC_Write=1 at T+4.
5. Divide with reset mid-stall, DIV_CYCLES=32: rst asserted at T+10 -> outputs revert immediately; after rst deasserts, EX_MdStart=0 gives no stall.
6. HAZARD_PERF_CNT_EN defined: after tests 1 and 4, Stall_Count=5 and Flush_Count=0; after one taken branch, Flush_Count=1.
